// File: rtl/spi_burst_mem_pkg.sv
// Shared types and frame-field helpers for the burst-capable serial memory slave.
package spi_burst_mem_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_CMD,
    S_LEN,
    S_ADDR,
    S_WDATA,
    S_TURN,
    S_RDATA,
    S_DONE
  } state_t;

  localparam logic OP_WRITE = 1'b1;
  localparam logic OP_READ  = 1'b0;

  // Width of the opcode field that leads every frame.
  localparam int OP_W = 1;

  // Bit counter width large enough to index the widest frame field.
  function automatic int cnt_width(input int data_w, input int addr_w, input int len_w);
    int m;
    m = data_w;
    if (addr_w > m) m = addr_w;
    if (len_w > m) m = len_w;
    return (m < 2) ? 1 : $clog2(m);
  endfunction

endpackage

// File: rtl/spi_burst_mem_array.sv
// Word storage with one synchronous write port, one combinational read port
// and range checking for partially populated address spaces.
module spi_burst_mem_array #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 5,
  parameter int DEPTH  = 32
) (
  input  logic              clk,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic [ADDR_W-1:0] raddr,
  output logic [DATA_W-1:0] rdata,
  output logic              rd_oor
);

  logic [DATA_W-1:0] mem [DEPTH];
  logic              wr_ok;
  logic              rd_ok;

  assign wr_ok  = ({1'b0, waddr} < (ADDR_W+1)'(DEPTH));
  assign rd_ok  = ({1'b0, raddr} < (ADDR_W+1)'(DEPTH));
  assign rd_oor = !rd_ok;
  assign rdata  = rd_ok ? mem[raddr] : '0;

  // Commit a word only when its address is backed by real storage.
  always_ff @(posedge clk) begin
    if (we && wr_ok) mem[waddr] <= wdata;
  end

endmodule

// File: rtl/spi_burst_mem.sv
// Serial-framed memory slave: parses OP/LEN/ADDR frames, performs burst
// writes and reads with address auto-increment and out-of-range reporting.
module spi_burst_mem
  import spi_burst_mem_pkg::*;
#(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 5,
  parameter int DEPTH  = 32,
  parameter int LEN_W  = 3
) (
  input  logic clk,
  input  logic rst_n,
  input  logic cs,
  input  logic miso,
  output logic mosi,
  output logic ready,
  output logic op_done,
  output logic err
);

  localparam int CNT_W = cnt_width(DATA_W, ADDR_W, LEN_W);

  state_t            state, state_d;
  logic [CNT_W-1:0]  bit_cnt;
  logic [LEN_W-1:0]  word_cnt;
  logic [LEN_W-1:0]  len;
  logic [ADDR_W-1:0] addr;
  logic [ADDR_W-1:0] addr_inc;
  logic [ADDR_W-1:0] rd_addr;
  logic              op;
  logic [DATA_W-2:0] in_shift;
  logic [DATA_W-2:0] out_shift;
  logic              err_flag;
  logic              mosi_d, ready_d, op_done_d, err_d;
  logic              flag_set;
  logic              we;
  logic [DATA_W-1:0] wdata;
  logic [DATA_W-1:0] rd_data;
  logic              rd_oor;
  logic              last_len, last_addr, last_bit, last_word;

  assign last_len  = (bit_cnt == CNT_W'(LEN_W - 1));
  assign last_addr = (bit_cnt == CNT_W'(ADDR_W - 1));
  assign last_bit  = (bit_cnt == CNT_W'(DATA_W - 1));
  assign last_word = (word_cnt == len);
  assign addr_inc  = (addr == ADDR_W'(DEPTH - 1)) ? '0 : addr + 1'b1;
  assign rd_addr   = (state == S_RDATA) ? addr_inc : addr;
  assign wdata     = {miso, in_shift};

  spi_burst_mem_array #(
    .DATA_W(DATA_W),
    .ADDR_W(ADDR_W),
    .DEPTH (DEPTH)
  ) u_array (
    .clk   (clk),
    .we    (we),
    .waddr (addr),
    .wdata (wdata),
    .raddr (rd_addr),
    .rdata (rd_data),
    .rd_oor(rd_oor)
  );

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= state_d;
  end

  // Next-state logic: cs high aborts any active phase; DONE waits for cs high.
  always_comb begin
    state_d = state;
    case (state)
      S_IDLE:  if (!cs) state_d = S_CMD;
      S_CMD:   state_d = cs ? S_IDLE : S_LEN;
      S_LEN:   if (cs) state_d = S_IDLE;
               else if (last_len) state_d = S_ADDR;
      S_ADDR:  if (cs) state_d = S_IDLE;
               else if (last_addr) state_d = (op == OP_WRITE) ? S_WDATA : S_TURN;
      S_WDATA: if (cs) state_d = S_IDLE;
               else if (last_bit && last_word) state_d = S_DONE;
      S_TURN:  state_d = cs ? S_IDLE : S_RDATA;
      S_RDATA: if (cs) state_d = S_IDLE;
               else if (last_bit && last_word) state_d = S_DONE;
      S_DONE:  if (cs) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Output logic: next values of the registered outputs plus write/range strobes.
  always_comb begin
    mosi_d   = 1'b0;
    ready_d  = 1'b0;
    we       = 1'b0;
    flag_set = 1'b0;
    case (state)
      S_WDATA: if (!cs && last_bit) begin
        we       = 1'b1;
        flag_set = rd_oor;
      end
      S_TURN: if (!cs) begin
        mosi_d   = rd_data[0];
        ready_d  = 1'b1;
        flag_set = rd_oor;
      end
      S_RDATA: if (!cs) begin
        if (!last_bit) begin
          mosi_d  = out_shift[0];
          ready_d = 1'b1;
        end else if (!last_word) begin
          mosi_d   = rd_data[0];
          ready_d  = 1'b1;
          flag_set = rd_oor;
        end
      end
      default: ;
    endcase
    op_done_d = (state_d == S_DONE) && (state != S_DONE);
    err_d     = op_done_d && (err_flag || flag_set);
  end

  // Datapath: field capture, counters, shift registers and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bit_cnt   <= '0;
      word_cnt  <= '0;
      len       <= '0;
      addr      <= '0;
      op        <= 1'b0;
      in_shift  <= '0;
      out_shift <= '0;
      err_flag  <= 1'b0;
      mosi      <= 1'b0;
      ready     <= 1'b0;
      op_done   <= 1'b0;
      err       <= 1'b0;
    end else begin
      mosi    <= mosi_d;
      ready   <= ready_d;
      op_done <= op_done_d;
      err     <= err_d;
      if (flag_set) err_flag <= 1'b1;
      case (state)
        S_IDLE: begin
          bit_cnt  <= '0;
          word_cnt <= '0;
          err_flag <= 1'b0;
        end
        S_CMD: begin
          op      <= miso;
          bit_cnt <= '0;
        end
        S_LEN: begin
          len     <= {miso, len[LEN_W-1:1]};
          bit_cnt <= last_len ? '0 : bit_cnt + CNT_W'(1);
        end
        S_ADDR: begin
          addr    <= {miso, addr[ADDR_W-1:1]};
          bit_cnt <= last_addr ? '0 : bit_cnt + CNT_W'(1);
        end
        S_WDATA: begin
          in_shift <= {miso, in_shift[DATA_W-2:1]};
          if (last_bit) begin
            bit_cnt  <= '0;
            addr     <= addr_inc;
            word_cnt <= word_cnt + LEN_W'(1);
          end else begin
            bit_cnt <= bit_cnt + CNT_W'(1);
          end
        end
        S_TURN: begin
          out_shift <= rd_data[DATA_W-1:1];
          bit_cnt   <= '0;
        end
        S_RDATA: begin
          if (!last_bit) begin
            out_shift <= out_shift >> 1;
            bit_cnt   <= bit_cnt + CNT_W'(1);
          end else begin
            out_shift <= rd_data[DATA_W-1:1];
            addr      <= addr_inc;
            word_cnt  <= word_cnt + LEN_W'(1);
            bit_cnt   <= '0;
          end
        end
        default: ;
      endcase
    end
  end

endmodule
